// File: rtl/sram_arb_ctrl.sv
// Multi-channel SRAM access controller: round-robin arbitration of NCH requesters onto one
// single-port SRAM, with cs/we/oe sequencing, read-data capture and a one-cycle ack per channel.
module sram_arb_ctrl #(
   parameter int NCH    = 4,
   parameter int AW     = 5,
   parameter int DW     = 4,
   parameter int WR_CYC = 1,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NCH-1:0]    req,
   input  logic [NCH-1:0]    wr,
   input  logic [NCH*AW-1:0] addr,
   input  logic [NCH*DW-1:0] wdata,
   output logic [NCH-1:0]    ack,
   output logic [DW-1:0]     rdata,
   output logic              busy,
   output logic              cs,
   output logic              we,
   output logic              oe,
   output logic [AW-1:0]     mem_addr,
   output logic [DW-1:0]     mem_wdata,
   input  logic [DW-1:0]     mem_rdata
);

   localparam int IW   = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int MAXC = (WR_CYC > RD_LAT) ? WR_CYC : RD_LAT;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] WR_LAST = CW'(WR_CYC - 1);
   localparam logic [CW-1:0] RD_LAST = CW'(RD_LAT - 1);
   localparam logic [IW-1:0] LAST_CH = IW'(NCH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      ACK   = 2'd3
   } state_t;

   state_t state, next_state;

   logic [IW-1:0] ptr;
   logic [IW-1:0] grant;
   logic [IW-1:0] win_idx;
   logic [IW-1:0] idx_v;
   logic [IW-1:0] next_ptr;
   logic          win_valid;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;
   logic [CW-1:0] cnt;
   logic [AW-1:0] lat_addr;
   logic [DW-1:0] lat_wdata;
   logic [DW-1:0] rdata_q;
   logic          load;
   logic          cnt_clr;
   logic          cnt_inc;
   logic          capture;
   logic          ptr_adv;

   // Round-robin search starting at ptr; the first requester found wins.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      idx_v     = '0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int k = 0; k < NCH; k++) begin
         idx_v = IW'((int'(ptr) + k) % NCH);
         if (!win_valid && req[idx_v]) begin
            win_valid = 1'b1;
            win_idx   = idx_v;
         end
      end
      for (int k = 0; k < NCH; k++) begin
         if (win_idx == IW'(k)) begin
            sel_addr  = addr[k*AW +: AW];
            sel_wdata = wdata[k*DW +: DW];
         end
      end
   end

   assign next_ptr = (grant == LAST_CH) ? '0 : grant + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Outputs decode only from state and latched grant so live inputs never reach the SRAM pins.
   always_comb begin
      next_state = state;
      load       = 1'b0;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
      capture    = 1'b0;
      ptr_adv    = 1'b0;
      busy       = 1'b0;
      cs         = 1'b0;
      we         = 1'b0;
      oe         = 1'b0;
      ack        = '0;
      mem_addr   = '0;
      mem_wdata  = '0;
      case (state)
         IDLE: begin
            if (win_valid) begin
               load       = 1'b1;
               cnt_clr    = 1'b1;
               next_state = wr[win_idx] ? WRITE : READ;
            end
         end
         WRITE: begin
            busy      = 1'b1;
            cs        = 1'b1;
            we        = 1'b1;
            mem_addr  = lat_addr;
            mem_wdata = lat_wdata;
            if (cnt == WR_LAST) begin
               next_state = ACK;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         READ: begin
            busy      = 1'b1;
            cs        = 1'b1;
            oe        = 1'b1;
            mem_addr  = lat_addr;
            mem_wdata = lat_wdata;
            if (cnt == RD_LAST) begin
               capture    = 1'b1;
               next_state = ACK;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         ACK: begin
            busy       = 1'b1;
            ack[grant] = 1'b1;
            mem_addr   = lat_addr;
            mem_wdata  = lat_wdata;
            ptr_adv    = 1'b1;
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Grant/address/data latch, cycle counter, read capture and pointer advance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant     <= '0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         cnt       <= '0;
         rdata_q   <= '0;
         ptr       <= '0;
      end else begin
         if (load) begin
            grant     <= win_idx;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
         end
         if (cnt_clr) begin
            cnt <= '0;
         end else if (cnt_inc) begin
            cnt <= cnt + 1'b1;
         end
         if (capture) begin
            rdata_q <= mem_rdata;
         end
         if (ptr_adv) begin
            ptr <= next_ptr;
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Table-driven bench for sram_arb_ctrl (WR_CYC=1, RD_LAT=3) with a small SRAM model,
// plus hand-written sequences for reset checks and a reset during a read.
module tb_sram_arb_ctrl;

   localparam int NCH    = 4;
   localparam int AW     = 5;
   localparam int DW     = 4;
   localparam int WR_CYC = 1;
   localparam int RD_LAT = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic [NCH-1:0]    req;
   logic [NCH-1:0]    wr;
   logic [NCH*AW-1:0] addr;
   logic [NCH*DW-1:0] wdata;
   logic [NCH-1:0]    ack;
   logic [DW-1:0]     rdata;
   logic              busy;
   logic              cs;
   logic              we;
   logic              oe;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     mem_wdata;
   logic [DW-1:0]     mem_rdata;

   int errors = 0;
   int checks = 0;

   sram_arb_ctrl #(
      .NCH(NCH), .AW(AW), .DW(DW), .WR_CYC(WR_CYC), .RD_LAT(RD_LAT)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
      .ack(ack), .rdata(rdata), .busy(busy), .cs(cs), .we(we), .oe(oe),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // SRAM model: location 3 preloaded with 4'hC, writes land on the edge ending a write cycle.
   logic [DW-1:0] mem [0:(1<<AW)-1] = '{3: 4'hC, default: 4'h0};

   always @(posedge clk) begin
      if (cs && we) mem[mem_addr] <= mem_wdata;
   end

   always_comb begin
      mem_rdata = (cs && oe) ? mem[mem_addr] : '0;
   end

   typedef struct {
      logic [3:0] req;
      logic [3:0] wr;
      logic [3:0] ack;
      logic [3:0] ctl;
      logic [4:0] maddr;
      logic [3:0] mwd;
      logic [1:0] chk;
      logic [3:0] rd;
   } vec_t;

   vec_t vec [0:63];
   int   nvec = 0;

   // ctl = {cs, we, oe, busy}; chk = {check mem_wdata, check rdata}
   task automatic add(input logic [3:0] rq, input logic [3:0] w, input logic [3:0] a,
                      input logic [3:0] c, input logic [4:0] ma, input logic [3:0] md,
                      input logic [1:0] ck, input logic [3:0] r);
      vec[nvec].req   = rq;
      vec[nvec].wr    = w;
      vec[nvec].ack   = a;
      vec[nvec].ctl   = c;
      vec[nvec].maddr = ma;
      vec[nvec].mwd   = md;
      vec[nvec].chk   = ck;
      vec[nvec].rd    = r;
      nvec++;
   endtask

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, " ack"}, 32'(ack), 32'h0);
      check_val({tag, " ctl"}, 32'({cs, we, oe, busy}), 32'h0);
      check_val({tag, " mem_addr"}, 32'(mem_addr), 32'h0);
      check_val({tag, " mem_wdata"}, 32'(mem_wdata), 32'h0);
      check_val({tag, " rdata"}, 32'(rdata), 32'h0);
   endtask

   task automatic apply_stimulus(input int i);
      req = vec[i].req;
      wr  = vec[i].wr;
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input int i);
      check_val($sformatf("row%0d ack", i), 32'(ack), 32'(vec[i].ack));
      check_val($sformatf("row%0d cs/we/oe/busy", i), 32'({cs, we, oe, busy}), 32'(vec[i].ctl));
      check_val($sformatf("row%0d mem_addr", i), 32'(mem_addr), 32'(vec[i].maddr));
      if (vec[i].chk[1]) check_val($sformatf("row%0d mem_wdata", i), 32'(mem_wdata), 32'(vec[i].mwd));
      if (vec[i].chk[0]) check_val($sformatf("row%0d rdata", i), 32'(rdata), 32'(vec[i].rd));
   endtask

   task automatic run_rows(input int first, input int last);
      for (int i = first; i <= last; i++) begin
         apply_stimulus(i);
         check_output(i);
      end
   endtask

   initial begin
      rst   = 1'b1;
      req   = '0;
      wr    = '0;
      addr  = {5'h1F, 5'h03, 5'h11, 5'h0A};
      wdata = {4'hE, 4'h9, 4'h5, 4'h7};

      // Part 1: single write ch0, read ch2 (RD_LAT=3), pointer wrap ch3 then ch1.
      add(4'b0001, 4'b0001, 4'b0000, 4'b1101, 5'h0A, 4'h7, 2'b10, 4'h0);
      add(4'b0001, 4'b0001, 4'b0001, 4'b0001, 5'h0A, 4'h7, 2'b10, 4'h0);
      add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 5'h00, 4'h0, 2'b10, 4'h0);
      for (int k = 0; k < 3; k++) add(4'b0100, 4'b0000, 4'b0000, 4'b1011, 5'h03, 4'h0, 2'b00, 4'h0);
      add(4'b0100, 4'b0000, 4'b0100, 4'b0001, 5'h03, 4'h9, 2'b11, 4'hC);
      add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 5'h00, 4'h0, 2'b11, 4'hC);
      add(4'b1010, 4'b1010, 4'b0000, 4'b1101, 5'h1F, 4'hE, 2'b10, 4'h0);
      add(4'b1010, 4'b1010, 4'b1000, 4'b0001, 5'h1F, 4'hE, 2'b10, 4'h0);
      add(4'b0010, 4'b0010, 4'b0000, 4'b0000, 5'h00, 4'h0, 2'b10, 4'h0);
      add(4'b0010, 4'b0010, 4'b0000, 4'b1101, 5'h11, 4'h5, 2'b10, 4'h0);
      add(4'b0010, 4'b0010, 4'b0010, 4'b0001, 5'h11, 4'h5, 2'b10, 4'h0);
      add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 5'h00, 4'h0, 2'b11, 4'hC);

      // Part 2 (after mid-read reset, ptr=0): four-way contention, second round, held request.
      add(4'b1111, 4'b1111, 4'b0000, 4'b1101, 5'h0A, 4'h7, 2'b10, 4'h0);
      add(4'b1111, 4'b1111, 4'b0001, 4'b0001, 5'h0A, 4'h7, 2'b10, 4'h0);
      add(4'b1110, 4'b1110, 4'b0000, 4'b0000, 5'h00, 4'h0, 2'b10, 4'h0);
      add(4'b1110, 4'b1110, 4'b0000, 4'b1101, 5'h11, 4'h5, 2'b10, 4'h0);
      add(4'b1110, 4'b1110, 4'b0010, 4'b0001, 5'h11, 4'h5, 2'b10, 4'h0);
      add(4'b1100, 4'b1100, 4'b0000, 4'b0000, 5'h00, 4'h0, 2'b10, 4'h0);
      add(4'b1100, 4'b1100, 4'b0000, 4'b1101, 5'h03, 4'h9, 2'b10, 4'h0);
      add(4'b1100, 4'b1100, 4'b0100, 4'b0001, 5'h03, 4'h9, 2'b10, 4'h0);
      add(4'b1000, 4'b1000, 4'b0000, 4'b0000, 5'h00, 4'h0, 2'b10, 4'h0);
      add(4'b1000, 4'b1000, 4'b0000, 4'b1101, 5'h1F, 4'hE, 2'b10, 4'h0);
      add(4'b1000, 4'b1000, 4'b1000, 4'b0001, 5'h1F, 4'hE, 2'b10, 4'h0);
      add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 5'h00, 4'h0, 2'b10, 4'h0);
      for (int k = 0; k < 3; k++) add(4'b0011, 4'b0000, 4'b0000, 4'b1011, 5'h0A, 4'h0, 2'b00, 4'h0);
      add(4'b0011, 4'b0000, 4'b0001, 4'b0001, 5'h0A, 4'h7, 2'b11, 4'h7);
      add(4'b0010, 4'b0000, 4'b0000, 4'b0000, 5'h00, 4'h0, 2'b11, 4'h7);
      for (int k = 0; k < 3; k++) add(4'b0010, 4'b0000, 4'b0000, 4'b1011, 5'h11, 4'h0, 2'b00, 4'h0);
      add(4'b0010, 4'b0000, 4'b0010, 4'b0001, 5'h11, 4'h5, 2'b11, 4'h5);
      add(4'b0010, 4'b0000, 4'b0000, 4'b0000, 5'h00, 4'h0, 2'b11, 4'h5);
      for (int k = 0; k < 3; k++) add(4'b0010, 4'b0000, 4'b0000, 4'b1011, 5'h11, 4'h0, 2'b00, 4'h0);
      add(4'b0010, 4'b0000, 4'b0010, 4'b0001, 5'h11, 4'h5, 2'b11, 4'h5);
      add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 5'h00, 4'h0, 2'b11, 4'h5);

      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      #3 rst = 1'b0;

      run_rows(0, 13);

      // Reset asserted in the middle of the second of three read cycles.
      req = 4'b0001;
      wr  = 4'b0000;
      @(posedge clk);
      #1;
      check_val("midrst read1 cs/we/oe/busy", 32'({cs, we, oe, busy}), 32'hB);
      @(posedge clk);
      #1;
      check_val("midrst read2 cs/we/oe/busy", 32'({cs, we, oe, busy}), 32'hB);
      check_val("midrst read2 mem_addr", 32'(mem_addr), 32'h0A);
      #2 rst = 1'b1;
      #1;
      check_all_zero("midrst async");
      req = 4'b0000;
      @(posedge clk);
      #1;
      check_all_zero("midrst held");
      #3 rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         check_val($sformatf("postrst%0d ack", k), 32'(ack), 32'h0);
         check_val($sformatf("postrst%0d busy", k), 32'(busy), 32'h0);
      end

      run_rows(14, nvec - 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sram_arb_ctrl.md
# sram_arb_ctrl

Multi-channel SRAM access controller: arbitrates up to NCH requesters onto one single-port SRAM and sequences the chip control signals with configurable write and read cycle counts. It sits between the client logic and the SRAM array, in place of the single-requester control FSM. It adds round-robin arbitration, address and data muxing, read-data capture, and a per-channel ack handshake.

## Interface
- NCH, default 4: number of requesting channels (≥2)
- AW, default 5: SRAM address width (depth 2^AW)
- DW, default 4: data width
- WR_CYC, default 1: cycles cs/we held per write (≥1)
- RD_LAT, default 1: cycles cs/oe held per read; data sampled on the last one (≥1)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  NCH  per-channel request; held until ack
- wr  in  NCH  per-channel op: 1=write, 0=read; valid while req high
- addr  in  NCH*AW  flat; channel i at [i*AW +: AW]
- wdata  in  NCH*DW  flat; channel i at [i*DW +: DW]
- ack  out  NCH  one-hot, 1-cycle completion pulse
- rdata  out  DW  read data; valid in the ack cycle of a read
- busy  out  1  high in any state except IDLE
- cs, we, oe  out  1 each  SRAM chip select, write enable, output enable
- mem_addr  out  AW  SRAM address
- mem_wdata  out  DW  SRAM write data
- mem_rdata  in  DW  SRAM read data

## Operation
- States: IDLE, WRITE, READ, ACK. Reset state is IDLE.
- IDLE:
  - If any req bit is high, pick the winner g by round-robin: search from ptr upward, wrapping modulo NCH.
  - Latch g, wr[g], addr[g] and wdata[g] into internal registers.
  - Go to WRITE if wr[g] is 1, else READ. Load the cycle counter with 0.
  - If no req is high, stay in IDLE.
- WRITE: cs=1, we=1, oe=0. mem_addr and mem_wdata come from the latched registers. Stay WR_CYC cycles, then go to ACK.
- READ: cs=1, oe=1, we=0. mem_addr comes from the latched register. Stay RD_LAT cycles. On the last cycle, capture mem_rdata into the rdata register, then go to ACK.
- ACK: cs/we/oe=0. ack[g]=1 for exactly one cycle. Set ptr = (g+1) mod NCH. Go to IDLE.
- Arbitration happens only in IDLE. Request changes during WRITE, READ or ACK are ignored.
- Requester hand-off: after seeing ack, the requester must drop req at the next edge. A req still high in the following IDLE cycle is treated as a new request.
- rdata holds its last captured value until the next read capture. It is undefined for writes and must be ignored by clients.
- cs/we/oe/ack/busy are decoded from the state registers and the latched grant, not from live inputs.
- mem_addr/mem_wdata are 0 in IDLE; in ACK they hold the latched values.
- Illegal state encodings return to IDLE on the next edge with all outputs 0.
- Reset (asynchronous, at any time, including mid-WRITE/READ):
  - state goes to IDLE, ptr and counter go to 0.
  - ack, cs, we, oe, busy, mem_addr, mem_wdata and rdata go to 0 immediately.
  - The in-flight transaction is dropped: no ack, no retry.

## Timing
- Request high in IDLE at edge t: grant is latched at t. WRITE/READ occupies cycles t+1 through t+N, where N = WR_CYC or RD_LAT. ack is high in cycle t+N+1.
- Throughput: one transaction per N+2 cycles, including the IDLE arbitration cycle.
- Write latency from request to ack: WR_CYC+1 cycles. Read latency: RD_LAT+1 cycles.
- mem_rdata must be stable at the rising edge that ends the last READ cycle.
- Reset values: all outputs 0; ptr=0; state=IDLE.

## Test plan
- Single write (defaults): ch0 req=1, wr=1, addr=5'h0A, wdata=4'h7 at t0.
  - t1: cs=we=1, oe=0, mem_addr=0A, mem_wdata=7.
  - t2: ack=4'b0001, cs=0.
  - t3: IDLE, busy=0.
- Read with RD_LAT=3: ch2 reads addr 5'h03 while the model drives mem_rdata=4'hC.
  - cs=oe=1 for exactly 3 cycles.
  - ack=4'b0100 with rdata=C in the 4th cycle.
- Contention: all 4 channels request at t0 and each drops req after its ack.
  - Acks arrive in order ch0, ch1, ch2, ch3, spaced 3 cycles apart (WR_CYC=1).
  - A second round starts again at ch0.
- Pointer wrap: ptr=3 (after serving ch2); ch1 and ch3 then request together.
  - ch3 is served first, ptr becomes 0, then ch1 is served.
- Reset mid-operation: assert rst during READ cycle 2 of 3 (RD_LAT=3).
  - All outputs are 0 immediately; no ack ever fires.
  - After release, ch0 request is serviced normally with ptr=0.
- Held request: ch1 keeps req high across its ack.
  - A second transaction starts in the IDLE cycle after the ack.
  - Back-to-back acks for ch1 are spaced N+2 cycles apart.
